// File: rtl/lcd12864_pkg.sv
// Shared definitions for the 12864 (ST7920) parallel-bus reader and writer:
// request kinds, FSM state codes, status-byte layout and DDRAM line bases.
package lcd12864_pkg;

  localparam logic [1:0] KIND_STATUS = 2'd0;
  localparam logic [1:0] KIND_DATA   = 2'd1;
  localparam logic [1:0] KIND_POLL   = 2'd2;
  localparam logic [1:0] KIND_RSVD   = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_EHIGH = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int BF_BIT = 7;

  // DDRAM "set address" commands for display lines 0..3
  localparam logic [3:0][7:0] LINE_BASE = {8'h98, 8'h88, 8'h90, 8'h80};

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } lcd_rsp_t;

  function automatic logic kind_rs(input logic [1:0] kind);
    return kind == KIND_DATA;
  endfunction

endpackage

// File: rtl/lcd12864_bus_phase.sv
// E-strobe phase timer: counts clk cycles within SETUP/EHIGH/HOLD and flags
// the last cycle of each phase plus the data sample cycle (last EHIGH cycle).
module lcd12864_bus_phase
  import lcd12864_pkg::*;
#(
  parameter int SETUP_CYC  = 8,
  parameter int E_HIGH_CYC = 16,
  parameter int HOLD_CYC   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       load,
  output logic       last,
  output logic       sample
);

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] EHIGH_LAST = 8'(E_HIGH_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

  logic [7:0] cnt;
  logic [7:0] limit;

  always_comb begin
    limit = 8'd0;
    case (state)
      ST_SETUP: limit = SETUP_LAST;
      ST_EHIGH: limit = EHIGH_LAST;
      ST_HOLD:  limit = HOLD_LAST;
      default:  limit = 8'd0;
    endcase
  end

  assign last   = (cnt == limit);
  assign sample = (state == ST_EHIGH) && last;

  // load marks entry into a new state; the count parks at the limit otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= 8'd0;
    else if (load)  cnt <= 8'd0;
    else if (!last) cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/lcd12864_bus_reader.sv
// Read-side master for the ST7920 8-bit bus: status/data reads and BF polling.
// Optional LCD12864_DUMMY_READ_EN: data reads issue a discarded dummy cycle first.
module lcd12864_bus_reader
  import lcd12864_pkg::*;
#(
  parameter int SETUP_CYC  = 8,
  parameter int E_HIGH_CYC = 16,
  parameter int HOLD_CYC   = 8,
  parameter int POLL_MAX   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_kind,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       bus_busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  input  logic [7:0] lcd_dat_in
);

  localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

  logic [2:0]  state, state_nxt;
  logic [1:0]  kind_q, kind_nxt;
  logic [7:0]  cap;
  logic [15:0] poll_cnt;
  lcd_rsp_t    rsp_q, hold_rsp;
  logic        accept, load, again, rw_nxt, hold_end;
  logic        phase_last, phase_sample;
`ifdef LCD12864_DUMMY_READ_EN
  logic        dummy_pend;
`endif

  assign accept    = req_valid && req_ready;
  assign load      = (state_nxt != state);
  assign hold_end  = (state == ST_HOLD) && phase_last;
  assign req_ready = (state == ST_IDLE);
  assign bus_busy  = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = rsp_q.data;
  assign rsp_err   = rsp_q.err;

  lcd12864_bus_phase #(
    .SETUP_CYC (SETUP_CYC),
    .E_HIGH_CYC(E_HIGH_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .load  (load),
    .last  (phase_last),
    .sample(phase_sample)
  );

  // End-of-HOLD decision: another bus cycle, or finish with the captured byte
  always_comb begin
    again    = 1'b0;
    hold_rsp = '{data: cap, err: 1'b0};
    if (kind_q == KIND_POLL && cap[BF_BIT]) begin
      if (poll_cnt < POLL_LIM) again = 1'b1;
      else                     hold_rsp.err = 1'b1;
    end
`ifdef LCD12864_DUMMY_READ_EN
    if (kind_q == KIND_DATA && dummy_pend) again = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = (req_kind == KIND_RSVD) ? ST_DONE : ST_SETUP;
      ST_SETUP: if (phase_last) state_nxt = ST_EHIGH;
      ST_EHIGH: if (phase_last) state_nxt = ST_HOLD;
      ST_HOLD:  if (phase_last) state_nxt = again ? ST_SETUP : ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign kind_nxt = accept ? req_kind : kind_q;
  assign rw_nxt   = (state_nxt == ST_SETUP) || (state_nxt == ST_EHIGH) ||
                    (state_nxt == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      kind_q <= KIND_STATUS;
    end else begin
      state <= state_nxt;
      if (accept) kind_q <= req_kind;
    end
  end

  // Bus pins are registered off the next state so they never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_rw <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_en <= 1'b0;
    end else begin
      lcd_rw <= rw_nxt;
      lcd_rs <= rw_nxt && kind_rs(kind_nxt);
      lcd_en <= (state_nxt == ST_EHIGH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cap <= 8'd0;
    else if (phase_sample) cap <= lcd_dat_in;
  end

  // Poll count is 1 for the first read and saturates rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt <= 16'd0;
    end else if (accept) begin
      poll_cnt <= 16'd1;
    end else if (hold_end && again && kind_q == KIND_POLL && poll_cnt != 16'hFFFF) begin
      poll_cnt <= poll_cnt + 16'd1;
    end
  end

`ifdef LCD12864_DUMMY_READ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   dummy_pend <= 1'b0;
    else if (accept)           dummy_pend <= (req_kind == KIND_DATA);
    else if (hold_end && again) dummy_pend <= 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '{data: 8'h00, err: 1'b0};
    end else if (accept && req_kind == KIND_RSVD) begin
      rsp_q <= '{data: 8'h00, err: 1'b1};
    end else if (hold_end && !again) begin
      rsp_q <= hold_rsp;
    end
  end

endmodule

// File: tb/tb_lcd12864_bus_reader.sv
// Randomized scoreboard bench for lcd12864_bus_reader with a behavioural LCD
// that serves queued bytes on each E pulse.
module tb_lcd12864_bus_reader;
  import lcd12864_pkg::*;

  localparam int SC  = 8;
  localparam int EC  = 16;
  localparam int HC  = 8;
  localparam int PM  = 5;
  localparam int BUS = SC + EC + HC;
`ifdef LCD12864_DUMMY_READ_EN
  localparam int DUMMY = 1;
`else
  localparam int DUMMY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_kind = 2'd0;
  logic [7:0] lcd_dat_in = 8'd0;
  logic       req_ready, rsp_valid, rsp_err, bus_busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] rsp_data;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
    logic       err;
    int         pulses;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] lcd_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd12864_bus_reader #(
    .SETUP_CYC(SC), .E_HIGH_CYC(EC), .HOLD_CYC(HC), .POLL_MAX(PM)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bus_busy(bus_busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_dat_in(lcd_dat_in)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // LCD model: each rising E serves the next queued byte
  always @(posedge lcd_en) begin
    if (lcd_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL lcd_read: E pulse with no byte queued (t=%0t)", $time);
      lcd_dat_in <= 8'h00;
    end else begin
      lcd_dat_in <= lcd_q.pop_front();
    end
  end
  always @(negedge lcd_en) lcd_dat_in <= 8'($urandom);

  // Monitor: pin-level tallies per transaction, compared when a response appears
  initial begin
    int   t_acc, en_cnt, rw_cnt, pulses;
    bit   active, en_prev, rs_bad;
    logic [7:0] last_data;
    exp_t e;
    t_acc = 0; en_cnt = 0; rw_cnt = 0; pulses = 0;
    active = 0; en_prev = 0; rs_bad = 0; last_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_cnt = 0; rw_cnt = 0; pulses = 0;
        active = 0; en_prev = 0; rs_bad = 0; last_data = 8'h00;
      end else begin
        chk("bus_busy", int'(bus_busy), int'(active));
        if (lcd_en) begin
          en_cnt++;
          if (!en_prev) pulses++;
          chk("rw_during_e", int'(lcd_rw), 1);
        end
        en_prev = lcd_en;
        if (lcd_rw) begin
          rw_cnt++;
          if (sb.size() > 0 && lcd_rs !== (sb[0].kind == KIND_DATA)) rs_bad = 1;
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_unexpected: data %0h err %0h (t=%0t)", rsp_data, rsp_err, $time);
          end else begin
            e = sb.pop_front();
            chk("rsp_data", int'(rsp_data), int'(e.data));
            chk("rsp_err", int'(rsp_err), int'(e.err));
            chk("latency", cyc - t_acc, e.lat);
            chk("e_pulses", pulses, e.pulses);
            chk("e_high_cycles", en_cnt, e.pulses * EC);
            chk("rw_cycles", rw_cnt, e.pulses * BUS);
            chk("rs_level", int'(rs_bad), 0);
          end
          last_data = rsp_data;
          en_cnt = 0; rw_cnt = 0; pulses = 0; rs_bad = 0;
          active = 0;
        end else begin
          chk("rsp_data_hold", int'(rsp_data), int'(last_data));
        end
        if (req_valid && req_ready) begin
          t_acc = cyc;
          active = 1;
        end
      end
    end
  end

  // Reference model: bytes the LCD will return and the response that results
  task automatic issue(input logic [1:0] k, input logic [7:0] d0,
                       input logic [7:0] d1, input int nb);
    exp_t e;
    bit   rdy;
    rdy = 0;
    for (int i = 0; i < 2000 && !rdy; i++) begin
      @(negedge clk);
      rdy = req_ready;
    end
    chk("req_ready_wait", int'(rdy), 1);
    e.kind = k;
    e.err  = 1'b0;
    case (k)
      KIND_STATUS: begin
        lcd_q.push_back(d0);
        e.data = d0; e.pulses = 1;
      end
      KIND_DATA: begin
        if (DUMMY != 0) lcd_q.push_back(d1);
        lcd_q.push_back(d0);
        e.data = d0; e.pulses = 1 + DUMMY;
      end
      KIND_POLL: begin
        if (nb < PM) begin
          for (int i = 0; i < nb; i++) lcd_q.push_back(d1 | 8'h80);
          lcd_q.push_back(d0 & 8'h7F);
          e.data = d0 & 8'h7F; e.pulses = nb + 1;
        end else begin
          for (int i = 0; i < PM; i++) lcd_q.push_back(d1 | 8'h80);
          e.data = d1 | 8'h80; e.err = 1'b1; e.pulses = PM;
        end
      end
      default: begin
        e.data = 8'h00; e.err = 1'b1; e.pulses = 0;
      end
    endcase
    e.lat = (k == KIND_RSVD) ? 1 : 1 + e.pulses * BUS;
    sb.push_back(e);
    @(posedge clk); #2;
    req_valid = 1'b1; req_kind = k;
    @(posedge clk); #2;
    req_valid = 1'($urandom); req_kind = 2'($urandom);
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_req(input logic [1:0] k, input logic [7:0] d0,
                         input logic [7:0] d1, input int nb);
    issue(k, d0, d1, nb);
    wait_done();
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    #3;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_bus_busy", int'(bus_busy), 0);
    chk("rst_lcd_rs", int'(lcd_rs), 0);
    chk("rst_lcd_rw", int'(lcd_rw), 0);
    chk("rst_lcd_en", int'(lcd_en), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    run_req(KIND_STATUS, 8'h05, 8'h00, 0);
    run_req(KIND_DATA,   8'h41, 8'hFF, 0);
    run_req(KIND_POLL,   8'h12, 8'h80, 3);
    run_req(KIND_POLL,   8'h00, 8'h83, PM);
    run_req(KIND_RSVD,   8'h00, 8'h00, 0);

    // Reset during EHIGH of a status read
    issue(KIND_STATUS, 8'h5A, 8'h00, 0);
    n = 0;
    while (!lcd_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("e_rise_seen", int'(lcd_en), 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_lcd_en", int'(lcd_en), 0);
    chk("midrst_lcd_rw", int'(lcd_rw), 0);
    chk("midrst_bus_busy", int'(bus_busy), 0);
    chk("midrst_req_ready", int'(req_ready), 1);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    sb.delete();
    lcd_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("postrst_req_ready", int'(req_ready), 1);
    run_req(KIND_STATUS, 8'hA7, 8'h00, 0);

    for (int i = 0; i < 40; i++)
      run_req(2'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)));

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
